serial_packet_ctrl: RTL and testbench

- Receive-side sequencer for the push-button serial link feeding the multi-port seven-segment display path.
- Synchronizes the slow clkPB button strobe and SerIn into the clock domain and parses each packet: start bit, 2-bit port address, LEN_BITS length field, then N data bits.
- Steers each data bit to one of four output ports, with valid/done handshakes and a remaining-bit count for the display.

---
 rtl/serial_packet_ctrl.sv | 172 +++++++++++++++++
 tb/tb_serial_packet_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_packet_ctrl.sv
// Receive-side sequencer for the push-button serial link: start bit, 2-bit port, length field, data bits.
// Latency: registered outputs update SYNC_STAGES+1 clock edges after clk_pb is first sampled high.
// Backpressure: none; the sender paces every bit by hand, one strobe per clk_pb rise.
module serial_packet_ctrl #(
    parameter int LEN_BITS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ser_in,
    input  logic                clk_pb,
    output logic [3:0]          port_sel,
    output logic                ser_out,
    output logic                ser_out_valid,
    output logic                done,
    output logic                busy,
    output logic [LEN_BITS-1:0] data_remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_DONE
    } state_t;

    // Wide enough to count up to LEN_BITS-1 even when LEN_BITS is small.
    localparam int CW = $clog2(LEN_BITS + 1);

    logic [SYNC_STAGES-1:0] pb_sync_q;
    logic [SYNC_STAGES-1:0] ser_sync_q;
    logic                   edge_pb_q;
    logic                   strobe;
    logic                   sbit;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             addr_q, addr_d;
    logic [LEN_BITS-1:0]    len_q, len_d;
    logic [LEN_BITS-1:0]    len_shift;
    logic [LEN_BITS-1:0]    rem_q, rem_d;
    logic [3:0]             port_sel_q, port_sel_d;
    logic                   ser_out_q, ser_out_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    // Bring the button clock and data line into the clock domain; edge_pb_q remembers the previous synced level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pb_sync_q  <= '0;
            ser_sync_q <= '0;
            edge_pb_q  <= 1'b0;
        end else begin
            pb_sync_q  <= {pb_sync_q[SYNC_STAGES-2:0], clk_pb};
            ser_sync_q <= {ser_sync_q[SYNC_STAGES-2:0], ser_in};
            edge_pb_q  <= pb_sync_q[SYNC_STAGES-1];
        end
    end

    // One-cycle strobe per clk_pb rise, however long the button is held; the bit is sampled alongside it.
    assign strobe    = pb_sync_q[SYNC_STAGES-1] & ~edge_pb_q;
    assign sbit      = ser_sync_q[SYNC_STAGES-1];
    assign len_shift = (len_q << 1) | LEN_BITS'(sbit);

    // State and output registers; every output leaves the block from a flop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            port_sel_q <= '0;
            ser_out_q  <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            port_sel_q <= port_sel_d;
            ser_out_q  <= ser_out_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Packet parser: every field advances only on a strobe, except the single-cycle DONE state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        len_d      = len_q;
        rem_d      = rem_q;
        port_sel_d = port_sel_q;
        ser_out_d  = ser_out_q;
        valid_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A 0 on the idling-high line is the start bit.
                if (strobe && !sbit) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end
            end
            S_ADDR: begin
                if (strobe) begin
                    addr_d = {addr_q[0], sbit};
                    if (cnt_q == CW'(1)) begin
                        state_d = S_LEN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_LEN: begin
                if (strobe) begin
                    len_d = len_shift;
                    if (cnt_q == CW'(LEN_BITS - 1)) begin
                        // Port is committed together with the length so the display sees both at once.
                        rem_d      = len_shift;
                        port_sel_d = 4'b0001 << addr_q;
                        state_d    = (len_shift == '0) ? S_DONE : S_DATA;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DATA: begin
                if (strobe) begin
                    ser_out_d = sbit;
                    valid_d   = 1'b1;
                    if (rem_q != '0) begin
                        rem_d = rem_q - LEN_BITS'(1);
                    end
                    if (rem_q <= LEN_BITS'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Any strobe landing here is dropped; the protocol never sends one.
                state_d    = S_IDLE;
                port_sel_d = '0;
            end
            default: begin
                state_d    = S_IDLE;
                port_sel_d = '0;
            end
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    assign port_sel       = port_sel_q;
    assign ser_out        = ser_out_q;
    assign ser_out_valid  = valid_q;
    assign done           = done_q;
    assign busy           = busy_q;
    assign data_remaining = rem_q;

endmodule

// File: tb/tb_serial_packet_ctrl.sv
module tb_serial_packet_ctrl;

    localparam int LEN  = 4;
    localparam int SYNC = 2;

    logic           clock  = 1'b0;
    logic           reset  = 1'b0;
    logic           ser_in = 1'b1;
    logic           clk_pb = 1'b0;
    logic [3:0]     port_sel;
    logic           ser_out;
    logic           ser_out_valid;
    logic           done;
    logic           busy;
    logic [LEN-1:0] data_remaining;

    typedef struct packed {
        logic           is_done;
        logic [3:0]     ps;
        logic           b;
        logic [LEN-1:0] rem;
    } ev_t;

    ev_t obs_q[$];
    int  obs_cyc[$];
    ev_t exp_q[$];
    bit  stim_q[$];

    int cyc       = 0;
    int ps_cycles = 0;
    int obs_base  = 0;
    int rise_cyc  = 0;
    int n_checks  = 0;
    int n_pass    = 0;
    int n_fail    = 0;

    serial_packet_ctrl #(.LEN_BITS(LEN), .SYNC_STAGES(SYNC)) dut (
        .clock          (clock),
        .reset          (reset),
        .ser_in         (ser_in),
        .clk_pb         (clk_pb),
        .port_sel       (port_sel),
        .ser_out        (ser_out),
        .ser_out_valid  (ser_out_valid),
        .done           (done),
        .busy           (busy),
        .data_remaining (data_remaining)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every delivered bit and every done pulse, stamped with the clock edge that produced it.
    always @(negedge clock) begin
        if (reset) begin
            if (ser_out_valid) begin
                obs_q.push_back('{is_done: 1'b0, ps: port_sel, b: ser_out, rem: data_remaining});
                obs_cyc.push_back(cyc);
            end
            if (done) begin
                obs_q.push_back('{is_done: 1'b1, ps: port_sel, b: 1'b0, rem: '0});
                obs_cyc.push_back(cyc);
            end
            if (port_sel != 4'b0000) ps_cycles = ps_cycles + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) stim_q.push_back(v[k]);
    endtask

    task automatic push_rand(input int n);
        for (int k = 0; k < n; k++) stim_q.push_back(bit'($urandom_range(0, 1)));
    endtask

    // Reference: parse the bit stream by the packet rules and list the events the display should see.
    task automatic model();
        int  i;
        int  addr;
        int  len;
        ev_t e;
        i = 0;
        while (i < stim_q.size()) begin
            if (stim_q[i]) begin
                i++;
            end else begin
                addr = 2 * int'(stim_q[i+1]) + int'(stim_q[i+2]);
                len  = 0;
                for (int k = 0; k < LEN; k++) len = 2 * len + int'(stim_q[i+3+k]);
                i = i + 3 + LEN;
                for (int d = 0; d < len; d++) begin
                    e.is_done = 1'b0;
                    e.ps      = 4'(1 << addr);
                    e.b       = stim_q[i+d];
                    e.rem     = LEN'(len - 1 - d);
                    exp_q.push_back(e);
                end
                e.is_done = 1'b1;
                e.ps      = 4'(1 << addr);
                e.b       = 1'b0;
                e.rem     = '0;
                exp_q.push_back(e);
                i = i + len;
            end
        end
    endtask

    task automatic send_bit(input bit b, input int hold);
        @(negedge clock);
        ser_in = b;
        repeat (2) @(negedge clock);
        clk_pb   = 1'b1;
        rise_cyc = cyc;
        repeat (hold) @(negedge clock);
        clk_pb = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    // hold==0 picks a random press length per bit.
    task automatic send_range(input int lo, input int hi, input int hold);
        for (int i = lo; i < hi; i++)
            send_bit(stim_q[i], (hold == 0) ? int'($urandom_range(1, 8)) : hold);
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, 32'(obs_q.size() - obs_base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && obs_base + k < obs_q.size(); k++)
            check(tag, 32'(obs_q[obs_base+k]), 32'(exp_q[k]));
        obs_base = obs_q.size();
        exp_q.delete();
        stim_q.delete();
    endtask

    initial begin
        int ps0;
        int n;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_outputs", 32'({port_sel, ser_out, ser_out_valid, done, busy, data_remaining}), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("release_no_strobe_busy", 32'(busy), 32'd0);

        // Idle line: presses with ser_in=1 produce nothing
        push_bits(32'b111, 3);
        model();
        send_range(0, 3, 4);
        check("idle_busy", 32'(busy), 32'd0);
        compare("idle_events");

        // Packet 0 10 0011 010
        push_bits(32'b0100011, 7);
        push_bits(32'b010, 3);
        model();
        send_range(0, 7, 3);
        check("A_port_sel", 32'(port_sel), 32'b0100);
        check("A_remaining", 32'(data_remaining), 32'd3);
        check("A_busy_mid", 32'(busy), 32'd1);
        send_range(7, 10, 3);
        n = obs_q.size();
        if (n - obs_base >= 2) check("A_done_on_last_bit_edge", 32'(obs_cyc[n-1]), 32'(obs_cyc[n-2]));
        compare("A_events");
        check("A_port_sel_after", 32'(port_sel), 32'd0);
        check("A_busy_after", 32'(busy), 32'd0);
        push_bits(32'b11, 2);
        model();
        send_range(0, 2, 3);
        compare("A_trailing");

        // Zero-length packet: port held only during the done cycle
        ps0 = ps_cycles;
        push_bits(32'b0110000, 7);
        model();
        send_range(0, 7, 3);
        check("Z_port_sel_cycles", 32'(ps_cycles - ps0), 32'd1);
        compare("Z_events");

        // Long presses: one strobe per press, fixed latency from clk_pb rise
        push_bits(32'b0000010, 7);
        push_bits(32'b11, 2);
        model();
        send_range(0, 9, 50);
        n = obs_q.size();
        if (n - obs_base >= 2) check("hold_latency", 32'(obs_cyc[n-2] - rise_cyc), 32'(SYNC + 1));
        compare("hold_events");

        // Asynchronous reset after one of three data bits
        push_bits(32'b0100011, 7);
        push_bits(32'b0, 1);
        send_range(0, 8, 3);
        @(posedge clock);
        #2 reset = 1'b0;
        #1 check("async_reset_outputs", 32'({port_sel, ser_out, ser_out_valid, done, busy, data_remaining}), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        obs_base = obs_q.size();
        stim_q.delete();
        repeat (3) @(negedge clock);
        check("post_reset_busy", 32'(busy), 32'd0);
        push_bits(32'b0010001, 7);
        push_bits(32'b1, 1);
        model();
        send_range(0, 8, 3);
        compare("R_events");

        // Back-to-back maximum-length packets to port 0 then port 3
        push_bits(32'b0001111, 7);
        push_rand(15);
        push_bits(32'b0111111, 7);
        push_rand(15);
        model();
        send_range(0, stim_q.size(), 2);
        compare("B2B_events");

        // Random packets with random idle gaps and press lengths
        for (int p = 0; p < 12; p++) begin
            push_bits(32'b111, int'($urandom_range(0, 2)));
            stim_q.push_back(1'b0);
            push_bits(32'($urandom_range(0, 3)), 2);
            n = int'($urandom_range(0, 15));
            push_bits(32'(n), LEN);
            push_rand(n);
        end
        model();
        send_range(0, stim_q.size(), 0);
        compare("rand_events");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
